// File: rtl/behavioral_not_unit.sv
// Bit-wise inverter with a combinational output and a one-entry registered,
// handshaked output stage plus an accepted-transaction counter.
module behavioral_not_unit #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] y_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] txn_cnt
);

  logic [WIDTH-1:0] y_q_r;
  logic             out_valid_r;
  logic [CNT_W-1:0] txn_cnt_r;
  logic             in_ready_s;
  logic             accept_s;
  logic             consume_s;

  function automatic logic [WIDTH-1:0] invert(input logic [WIDTH-1:0] v);
    return ~v;
  endfunction

  assign y          = invert(a);
  // Ready depends only on the output stage, never on in_valid.
  assign in_ready_s = !out_valid_r || out_ready;
  assign accept_s   = in_valid && in_ready_s;
  assign consume_s  = out_valid_r && out_ready;

  assign in_ready   = in_ready_s;
  assign y_q        = y_q_r;
  assign out_valid  = out_valid_r;
  assign txn_cnt    = txn_cnt_r;

  // Output register, occupancy flag and wrapping transaction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q_r       <= '0;
      out_valid_r <= 1'b0;
      txn_cnt_r   <= '0;
    end else if (accept_s) begin
      y_q_r       <= invert(a);
      out_valid_r <= 1'b1;
      txn_cnt_r   <= txn_cnt_r + CNT_W'(1);
    end else if (consume_s) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

endmodule

// File: tb/tb_behavioral_not_unit.sv
// Scoreboard bench for behavioral_not_unit: driver pushes expected y_q values,
// an independent monitor pops and compares on every consume.
module tb_behavioral_not_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rst1_n;
  logic [7:0] a;
  logic [7:0] y;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] y_q;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] txn_cnt;

  logic       a1;
  logic       y1;
  logic       w1_in_ready;
  logic       w1_y_q;
  logic       w1_out_valid;
  logic [3:0] w1_txn_cnt;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] sb[$];
  logic       model_ov;
  logic [3:0] exp_cnt;

  always #5 clk = ~clk;

  behavioral_not_unit #(.WIDTH(8), .CNT_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .y(y),
    .in_valid(in_valid), .in_ready(in_ready),
    .y_q(y_q), .out_valid(out_valid), .out_ready(out_ready),
    .txn_cnt(txn_cnt)
  );

  behavioral_not_unit #(.WIDTH(1), .CNT_W(4)) u_w1 (
    .clk(clk), .rst_n(rst1_n), .a(a1), .y(y1),
    .in_valid(1'b0), .in_ready(w1_in_ready),
    .y_q(w1_y_q), .out_valid(w1_out_valid), .out_ready(1'b0),
    .txn_cnt(w1_txn_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: sample a settled cycle; a consume will happen at the next edge.
  always begin
    @(negedge clk);
    #2;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_output", 64'(y_q), 64'hDEAD);
      end else begin
        check("sb_y_q", 64'(y_q), 64'(sb.pop_front()));
      end
    end
  end

  // One clock of stimulus; called at a falling edge, returns at the next one.
  task automatic step(input logic v, input logic [7:0] d);
    logic exp_ready;
    logic acc;
    in_valid  = v;
    a         = d;
    exp_ready = !model_ov || out_ready;
    acc       = v && exp_ready;
    #1;
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    if (acc) begin
      sb.push_back(~d);
      exp_cnt = exp_cnt + 4'd1;
    end
    @(posedge clk);
    if (acc) model_ov = 1'b1;
    else if (model_ov && out_ready) model_ov = 1'b0;
    @(negedge clk);
    check("out_valid", 64'(out_valid), 64'(model_ov));
    check("txn_cnt", 64'(txn_cnt), 64'(exp_cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n     = 1'b0;
    rst1_n    = 1'b0;
    a         = 8'h3C;
    a1        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    model_ov  = 1'b0;
    exp_cnt   = 4'd0;

    // Combinational truth table while held in reset.
    #5  a1 = 1'b0;
    #1  check("y_w1_a0", 64'(y1), 64'h1);
    #4  a1 = 1'b1;
    #1  check("y_w1_a1", 64'(y1), 64'h0);
    check("y_w8_rst", 64'(y), 64'hC3);
    check("rst_y_q", 64'(y_q), 64'h0);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_txn_cnt", 64'(txn_cnt), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming with out_ready held high.
    out_ready = 1'b1;
    step(1'b1, 8'h00);
    step(1'b1, 8'hFF);
    step(1'b1, 8'hA5);
    check("stream_cnt3", 64'(txn_cnt), 64'h3);
    step(1'b0, 8'h00);

    // Back-pressure: one accepted, then three stalled offers.
    out_ready = 1'b0;
    step(1'b1, 8'h0F);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hF0);
      check("bp_y_q_hold", 64'(y_q), 64'hF0);
    end
    check("bp_cnt", 64'(txn_cnt), 64'h4);
    out_ready = 1'b1;
    step(1'b1, 8'hF0);
    check("bp_release_y_q", 64'(y_q), 64'h0F);
    check("bp_release_cnt", 64'(txn_cnt), 64'h5);

    // Simultaneous accept and consume: no bubble.
    step(1'b1, 8'h3C);
    check("sim_y_q", 64'(y_q), 64'hC3);
    check("sim_no_bubble", 64'(out_valid), 64'h1);
    step(1'b0, 8'h00);

    // Reset mid-transaction discards the pending result immediately.
    out_ready = 1'b0;
    step(1'b1, 8'hA5);
    check("pre_rst_y_q", 64'(y_q), 64'h5A);
    in_valid = 1'b0;
    #4 rst_n = 1'b0;
    #1;
    check("mid_rst_y_q", 64'(y_q), 64'h0);
    check("mid_rst_out_valid", 64'(out_valid), 64'h0);
    check("mid_rst_txn_cnt", 64'(txn_cnt), 64'h0);
    check("mid_rst_in_ready", 64'(in_ready), 64'h1);
    sb.delete();
    model_ov = 1'b0;
    exp_cnt  = 4'd0;
    @(negedge clk);
    rst_n = 1'b1;

    // Counter wrap: 17 accepts give 1..15, 0, 1.
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 8'(i * 13));
    end
    check("wrap_cnt", 64'(txn_cnt), 64'h1);
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    check("sb_drained", 64'(sb.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
